pixel_stream_checker: RTL and testbench

- Synthesizable self-checking comparator for two pixel streams: A is the DUT output stream and B is the golden/reference stream.
- Compares NUM_PIX pixels pairwise within an absolute tolerance and accumulates statistics.
- Captures the first mismatch and reports pass/fail.
- Sits at the output of the convolution datapath, replacing file-based post-run comparison with in-simulation, on-the-fly checking.

---
 rtl/pixel_stream_checker.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pixel_stream_checker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_checker.sv
// -----------------------------------------------------------------------------
// pixel_stream_checker
//   Compares a DUT pixel stream (A) against a golden stream (B) pairwise, over
//   NUM_PIX pixels, within an absolute tolerance TOL.
//   - Each stream enters through its own small skew FIFO. This lets the two
//     streams arrive out of step with each other.
//   - A pair is popped and compared only when both FIFOs hold data.
//   - The block accumulates match/mismatch counts and the largest error.
//   - It captures the first mismatch and reports done/pass.
//
// Ports
//   clk, rst               : rising-edge clock, synchronous active-high reset
//   start                  : one-cycle pulse that begins a frame (ignored in RUN)
//   a_valid/a_data/a_ready : DUT stream input with ready handshake
//   b_valid/b_data/b_ready : golden stream input with ready handshake
//   busy                   : checker is in RUN
//   done, pass             : frame finished / finished with zero mismatches
//   cmp_valid, cmp_match   : per-pair result pulse, one cycle after the pop
//   match_cnt, mism_cnt    : pairs within / outside tolerance (mism saturates)
//   max_err                : largest |A-B| this frame
//   first_vld/idx/a/b      : first mismatch record, never overwritten
// -----------------------------------------------------------------------------

// Small synchronous FIFO used to absorb skew on one stream.
// The read head is visible combinationally on rdata.
module pixel_stream_checker_fifo #(
    parameter int W = 12,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem_r [D];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   cnt_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign empty     = (cnt_r == '0);
    assign full      = (cnt_r == (AW+1)'(D));
    assign rdata     = mem_r[rd_ptr_r];
    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Storage array write; contents need no reset because pointers gate reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_r <= cnt_r + (AW+1)'(1);
                2'b01:   cnt_r <= cnt_r - (AW+1)'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end
endmodule

module pixel_stream_checker #(
    parameter int DATA_W  = 12,
    parameter int NUM_PIX = 65536,
    parameter int TOL     = 0,
    parameter int FIFO_D  = 4,
    parameter int CNT_W   = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              cmp_valid,
    output logic              cmp_match,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  mism_cnt,
    output logic [DATA_W-1:0] max_err,
    output logic              first_vld,
    output logic [CNT_W-1:0]  first_idx,
    output logic [DATA_W-1:0] first_a,
    output logic [DATA_W-1:0] first_b
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  idx_r;
    logic              run_s;
    logic              clear_s;
    logic              a_full_s;
    logic              a_empty_s;
    logic              b_full_s;
    logic              b_empty_s;
    logic [DATA_W-1:0] a_head_s;
    logic [DATA_W-1:0] b_head_s;
    logic              pop_s;
    logic              last_s;
    logic [DATA_W-1:0] absdiff_s;
    logic              match_s;
    logic [CNT_W-1:0]  mism_next_s;

    // |x-y| via a (DATA_W+1)-bit signed difference. The result always fits in
    // DATA_W bits.
    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
        logic [DATA_W:0] d;
        logic [DATA_W:0] n;
        d = {1'b0, x} - {1'b0, y};
        n = -d;
        if (d[DATA_W]) begin
            return n[DATA_W-1:0];
        end else begin
            return d[DATA_W-1:0];
        end
    endfunction

    assign run_s   = (state_r == ST_RUN);
    // start only takes effect outside RUN. It also flushes leftover FIFO data.
    assign clear_s = start && !run_s;
    // Ready depends on full alone, so a full FIFO stays closed even while popping.
    assign a_ready = run_s && !a_full_s;
    assign b_ready = run_s && !b_full_s;
    assign pop_s   = run_s && !a_empty_s && !b_empty_s;
    assign last_s  = (idx_r == CNT_W'(NUM_PIX - 1));

    pixel_stream_checker_fifo #(.W(DATA_W), .D(FIFO_D)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .flush (clear_s),
        .push  (a_valid && a_ready),
        .wdata (a_data),
        .pop   (pop_s),
        .rdata (a_head_s),
        .empty (a_empty_s),
        .full  (a_full_s)
    );

    pixel_stream_checker_fifo #(.W(DATA_W), .D(FIFO_D)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .flush (clear_s),
        .push  (b_valid && b_ready),
        .wdata (b_data),
        .pop   (pop_s),
        .rdata (b_head_s),
        .empty (b_empty_s),
        .full  (b_full_s)
    );

    // Compare the current FIFO heads. The mismatch count sticks at all ones.
    always_comb begin
        absdiff_s   = abs_diff(a_head_s, b_head_s);
        match_s     = (absdiff_s <= DATA_W'(TOL));
        mism_next_s = mism_cnt;
        if (pop_s && !match_s && (mism_cnt != {CNT_W{1'b1}})) begin
            mism_next_s = mism_cnt + CNT_W'(1);
        end else begin
            mism_next_s = mism_cnt;
        end
    end

    // Control FSM plus all registered results and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            idx_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_match <= 1'b0;
            match_cnt <= '0;
            mism_cnt  <= '0;
            max_err   <= '0;
            first_vld <= 1'b0;
            first_idx <= '0;
            first_a   <= '0;
            first_b   <= '0;
        end else begin
            cmp_valid <= pop_s;
            cmp_match <= pop_s && match_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        busy      <= 1'b1;
                        idx_r     <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        match_cnt <= '0;
                        mism_cnt  <= '0;
                        max_err   <= '0;
                        first_vld <= 1'b0;
                        first_idx <= '0;
                        first_a   <= '0;
                        first_b   <= '0;
                    end
                end
                ST_RUN: begin
                    if (pop_s) begin
                        idx_r    <= idx_r + CNT_W'(1);
                        mism_cnt <= mism_next_s;
                        if (match_s) begin
                            match_cnt <= match_cnt + CNT_W'(1);
                        end
                        if (absdiff_s > max_err) begin
                            max_err <= absdiff_s;
                        end
                        // Only the first mismatch of the frame is recorded.
                        if (!match_s && !first_vld) begin
                            first_vld <= 1'b1;
                            first_idx <= idx_r;
                            first_a   <= a_head_s;
                            first_b   <= b_head_s;
                        end
                        if (last_s) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (mism_next_s == '0);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_stream_checker.sv
// Directed/randomized bench for pixel_stream_checker. Two instances share the
// same stimulus: one with TOL=0 and one with TOL=3. Expectations come from
// per-frame pixel arrays evaluated with plain arithmetic.
module tb_pixel_stream_checker;
    localparam int DW = 12;
    localparam int N  = 16;
    localparam int FD = 4;
    localparam int CW = 5;

    logic clk = 1'b0;
    logic rst, start, a_valid, b_valid;
    logic [DW-1:0] a_data, b_data;

    logic a_ready, b_ready, busy, done, pass, cmp_valid, cmp_match, first_vld;
    logic [CW-1:0] match_cnt, mism_cnt, first_idx;
    logic [DW-1:0] max_err, first_a, first_b;

    logic t_a_ready, t_b_ready, t_busy, t_done, t_pass, t_cmp_valid, t_cmp_match, t_first_vld;
    logic [CW-1:0] t_match_cnt, t_mism_cnt, t_first_idx;
    logic [DW-1:0] t_max_err, t_first_a, t_first_b;

    int vec_cnt = 0;
    int err_cnt = 0;
    int a_px[N];
    int b_px[N];
    int pulse_k = 0;
    int frame_base = 0;
    int a_acc = 0;

    always #5 clk = ~clk;

    pixel_stream_checker #(.DATA_W(DW), .NUM_PIX(N), .TOL(0), .FIFO_D(FD), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .busy(busy), .done(done), .pass(pass),
        .cmp_valid(cmp_valid), .cmp_match(cmp_match),
        .match_cnt(match_cnt), .mism_cnt(mism_cnt), .max_err(max_err),
        .first_vld(first_vld), .first_idx(first_idx), .first_a(first_a), .first_b(first_b)
    );

    pixel_stream_checker #(.DATA_W(DW), .NUM_PIX(N), .TOL(3), .FIFO_D(FD), .CNT_W(CW)) dut_t3 (
        .clk(clk), .rst(rst), .start(start),
        .a_valid(a_valid), .a_data(a_data), .a_ready(t_a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(t_b_ready),
        .busy(t_busy), .done(t_done), .pass(t_pass),
        .cmp_valid(t_cmp_valid), .cmp_match(t_cmp_match),
        .match_cnt(t_match_cnt), .mism_cnt(t_mism_cnt), .max_err(t_max_err),
        .first_vld(t_first_vld), .first_idx(t_first_idx), .first_a(t_first_a), .first_b(t_first_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int adiff(input int x, input int y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    // Count A pixels actually accepted (valid and ready at the clock edge).
    always @(posedge clk) begin
        if (a_valid && a_ready) a_acc <= a_acc + 1;
    end

    // Check each result pulse against the frame arrays, in pop order.
    always @(negedge clk) begin
        if (!rst && cmp_valid) begin
            int mi;
            mi = pulse_k - frame_base;
            if (mi < N) begin
                chk("cmp_match_tol0", cmp_match, adiff(a_px[mi], b_px[mi]) <= 0);
                chk("cmp_match_tol3", t_cmp_match, adiff(a_px[mi], b_px[mi]) <= 3);
                chk("done_on_last", done, mi == N - 1);
            end else begin
                chk("pulse_overrun", mi, N - 1);
            end
            pulse_k <= pulse_k + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_a(input int n, input int delay, input int gap_max);
        int w;
        a_valid = 1'b0;
        repeat (delay) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin a_valid = 1'b0; @(negedge clk); end
            a_valid = 1'b1;
            a_data  = DW'(a_px[i]);
            w = 0;
            while (!a_ready && w < 300) begin @(negedge clk); w++; end
            if (w >= 300) begin chk("a_accept_timeout", w, 0); break; end
            @(negedge clk);
        end
        a_valid = 1'b0;
    endtask

    task automatic drive_b(input int n, input int delay, input int gap_max);
        int w;
        b_valid = 1'b0;
        repeat (delay) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) begin b_valid = 1'b0; @(negedge clk); end
            b_valid = 1'b1;
            b_data  = DW'(b_px[i]);
            w = 0;
            while (!b_ready && w < 300) begin @(negedge clk); w++; end
            if (w >= 300) begin chk("b_accept_timeout", w, 0); break; end
            @(negedge clk);
        end
        b_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Final statistics for both tolerances, computed straight from the arrays.
    task automatic check_frame(input string name);
        int em0, mm0, em1, mm1, mx, fi, fa, fb, d;
        bit fv;
        em0 = 0; mm0 = 0; em1 = 0; mm1 = 0; mx = 0; fi = 0; fa = 0; fb = 0; fv = 0;
        for (int i = 0; i < N; i++) begin
            d = adiff(a_px[i], b_px[i]);
            if (d > mx) mx = d;
            if (d == 0) em0++;
            else begin
                mm0++;
                if (!fv) begin fv = 1; fi = i; fa = a_px[i]; fb = b_px[i]; end
            end
            if (d <= 3) em1++; else mm1++;
        end
        chk({name, ".pulses"}, pulse_k - frame_base, N);
        chk({name, ".done"}, done, 1);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".match_cnt"}, match_cnt, em0);
        chk({name, ".mism_cnt"}, mism_cnt, mm0);
        chk({name, ".max_err"}, max_err, mx);
        chk({name, ".pass"}, pass, mm0 == 0);
        chk({name, ".first_vld"}, first_vld, fv);
        chk({name, ".first_idx"}, first_idx, fi);
        chk({name, ".first_a"}, first_a, fa);
        chk({name, ".first_b"}, first_b, fb);
        chk({name, ".t3_match_cnt"}, t_match_cnt, em1);
        chk({name, ".t3_mism_cnt"}, t_mism_cnt, mm1);
        chk({name, ".t3_max_err"}, t_max_err, mx);
        chk({name, ".t3_pass"}, t_pass, mm1 == 0);
    endtask

    task automatic run_frame(input string name, input int db, input int ga, input int gb,
                             input bit skew_chk, input bit mid_start);
        int w;
        int acc_base;
        frame_base = pulse_k;
        acc_base   = a_acc;
        pulse_start();
        fork
            drive_a(N, 0, ga);
            drive_b(N, db, gb);
            begin
                if (skew_chk) begin
                    repeat (12) @(negedge clk);
                    chk({name, ".a_accepted_while_b_idle"}, a_acc - acc_base, FD);
                    chk({name, ".a_ready_full"}, a_ready, 0);
                end else if (mid_start) begin
                    repeat (5) @(negedge clk);
                    chk({name, ".busy_before_restart"}, busy, 1);
                    pulse_start();
                end
            end
        join
        w = 0;
        while (!done && w < 500) begin @(negedge clk); w++; end
        chk({name, ".done_timeout"}, done, 1);
        @(negedge clk);
        check_frame(name);
    endtask

    initial begin
        int w;
        rst = 1'b1; start = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        a_data = '0; b_data = '0;
        for (int i = 0; i < N; i++) begin a_px[i] = 0; b_px[i] = 0; end
        repeat (3) @(negedge clk);
        chk("rst.done", done, 0);
        chk("rst.pass", pass, 0);
        chk("rst.busy", busy, 0);
        chk("rst.a_ready", a_ready, 0);
        chk("rst.b_ready", b_ready, 0);
        chk("rst.match_cnt", match_cnt, 0);
        chk("rst.first_vld", first_vld, 0);
        rst = 1'b0;
        a_valid = 1'b1;
        @(negedge clk);
        chk("idle.a_ready", a_ready, 0);
        a_valid = 1'b0;

        // Identical streams, valid every cycle.
        for (int i = 0; i < N; i++) begin a_px[i] = $urandom_range(0, 4095); b_px[i] = a_px[i]; end
        run_frame("identical", 0, 0, 0, 1'b0, 1'b0);

        // Single small mismatch at index 5.
        for (int i = 0; i < N; i++) begin a_px[i] = $urandom_range(0, 4095); b_px[i] = a_px[i]; end
        a_px[5] = 12'h0A0; b_px[5] = 12'h0A3;
        run_frame("mism5", 0, 2, 2, 1'b0, 1'b0);

        // B held idle while A fills its FIFO, then both drain.
        for (int i = 0; i < N; i++) begin a_px[i] = $urandom_range(0, 4095); b_px[i] = a_px[i]; end
        b_px[3] = $urandom_range(0, 4095); b_px[11] = (a_px[11] + 2) % 4096;
        run_frame("skew", 20, 0, 0, 1'b1, 1'b0);

        // Extreme error first, later mismatch must not replace the record.
        for (int i = 0; i < N; i++) begin a_px[i] = $urandom_range(0, 4095); b_px[i] = a_px[i]; end
        a_px[0] = 0; b_px[0] = 4095; a_px[9] = (b_px[9] + 7) % 4096;
        run_frame("extremes", 0, 1, 1, 1'b0, 1'b0);

        // Small random errors around TOL, random gaps, start pulsed mid-run.
        for (int i = 0; i < N; i++) begin
            a_px[i] = $urandom_range(8, 4087);
            b_px[i] = a_px[i] + $urandom_range(0, 8) - 4;
        end
        run_frame("midstart", 0, 3, 3, 1'b0, 1'b1);

        // Reset after 7 compared pairs.
        for (int i = 0; i < N; i++) begin a_px[i] = $urandom_range(0, 4095); b_px[i] = a_px[i]; end
        b_px[2] = (a_px[2] + 9) % 4096;
        frame_base = pulse_k;
        pulse_start();
        fork
            drive_a(7, 0, 0);
            drive_b(7, 0, 0);
        join
        w = 0;
        while ((pulse_k - frame_base) < 7 && w < 50) begin @(negedge clk); w++; end
        chk("rst7.pairs", pulse_k - frame_base, 7);
        chk("rst7.mism_before", mism_cnt, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst7.match_cnt", match_cnt, 0);
        chk("rst7.mism_cnt", mism_cnt, 0);
        chk("rst7.max_err", max_err, 0);
        chk("rst7.first_vld", first_vld, 0);
        chk("rst7.busy", busy, 0);
        rst = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst7.a_ready", a_ready, 0);
        chk("rst7.b_ready", b_ready, 0);
        chk("rst7.done", done, 0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Fresh frame after reset with random mismatches.
        for (int i = 0; i < N; i++) begin
            a_px[i] = $urandom_range(0, 4095);
            b_px[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : a_px[i];
        end
        run_frame("fresh", 3, 2, 1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
